// File: rtl/tile_fetch_scheduler.sv
// Arbitrates the level-map RAM between the VGA tile prefetcher and game logic; optional SCHED_STATS_EN adds stall_cnt.
// Latency: game read data 1 cycle after grant; line prefetch occupies 11 cycles starting at DrawX==FETCH_X.
// Backpressure: gm_req is held off (gm_gnt=0) while a prefetch runs; prefetch always wins arbitration.
module tile_fetch_scheduler #(
    parameter int MAP_COLS = 64,
    parameter int ADDR_W   = 10,
    parameter int FETCH_X  = 640
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [ADDR_W-1:0] scroll_col,
    output logic [2:0]        blockID,
    input  logic              gm_req,
    input  logic              gm_we,
    input  logic [ADDR_W-1:0] gm_addr,
    input  logic [2:0]        gm_wdata,
    output logic              gm_gnt,
    output logic              gm_rvalid,
    output logic [2:0]        gm_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [2:0]        ram_wdata,
    input  logic [2:0]        ram_rdata,
`ifdef SCHED_STATS_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              line_miss
);

    typedef enum logic [1:0] {IDLE, PF, PD, GR} state_t;

    state_t            state_q, state_d;
    logic [3:0]        pf_cnt_q;
    logic [ADDR_W-1:0] scroll_q;
    logic [3:0]        row_q, row_d;
    logic [5:0]        sub_q, sub_d;
    logic              pf_pend_q;
    logic              fill_done_q;
    logic              act_q;
    logic              line_miss_q;
    logic [2:0]        lbuf [2][10];

    logic [9:0]        ny;
    logic              ny_win, y_win, in_win, trig, pf_start;
    logic [3:0]        pf_row, pf_c, col;
    logic [ADDR_W-1:0] pf_col0, pf_addr;

    assign ny       = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
    assign ny_win   = (ny >= 10'd40) && (ny <= 10'd439);
    assign y_win    = (DrawY >= 10'd40) && (DrawY <= 10'd439);
    assign trig     = (DrawX == 10'(FETCH_X)) && ny_win;
    assign pf_start = (state_q == IDLE) && (trig || pf_pend_q);

    // Row/subrow bookkeeping replaces (NY-40)/40; first window line re-syncs it.
    always_comb begin
        row_d = row_q;
        sub_d = sub_q + 6'd1;
        if (ny == 10'd40) begin
            row_d = '0;
            sub_d = '0;
        end else if (sub_q == 6'd39) begin
            row_d = row_q + 4'd1;
            sub_d = '0;
        end
    end

    // Tile 0 is issued in the trigger cycle itself from the live scroll_col.
    assign pf_row  = (state_q == IDLE) ? row_d : row_q;
    assign pf_col0 = (state_q == IDLE) ? scroll_col : scroll_q;
    assign pf_c    = (state_q == IDLE) ? 4'd0 : pf_cnt_q;
    assign pf_addr = ADDR_W'(pf_row) * ADDR_W'(MAP_COLS) + pf_col0 + ADDR_W'(pf_c);

    always_comb begin
        state_d   = state_q;
        gm_gnt    = 1'b0;
        gm_rvalid = 1'b0;
        gm_rdata  = '0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (Reset_n) begin
            case (state_q)
                IDLE: begin
                    if (pf_start) begin
                        ram_addr = pf_addr;
                        state_d  = PF;
                    end else if (gm_req) begin
                        gm_gnt    = 1'b1;
                        ram_addr  = gm_addr;
                        ram_we    = gm_we;
                        ram_wdata = gm_wdata;
                        if (!gm_we) state_d = GR;
                    end
                end
                PF: begin
                    ram_addr = pf_addr;
                    if (pf_cnt_q == 4'd9) state_d = PD;
                end
                PD: state_d = IDLE;
                GR: begin
                    gm_rvalid = 1'b1;
                    gm_rdata  = ram_rdata;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            pf_cnt_q    <= '0;
            scroll_q    <= '0;
            row_q       <= '0;
            sub_q       <= '0;
            pf_pend_q   <= 1'b0;
            fill_done_q <= 1'b0;
            act_q       <= 1'b0;
            line_miss_q <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 10; i++)
                    lbuf[b][i] <= '0;
        end else begin
            state_q <= state_d;
            if (pf_start) begin
                scroll_q  <= scroll_col;
                row_q     <= row_d;
                sub_q     <= sub_d;
                pf_cnt_q  <= 4'd1;
                pf_pend_q <= 1'b0;
            end else if (state_q == PF) begin
                pf_cnt_q <= pf_cnt_q + 4'd1;
            end
            if (state_q == GR && trig)
                pf_pend_q <= 1'b1;
            if (state_q == PF)
                lbuf[~act_q][pf_cnt_q - 4'd1] <= ram_rdata;
            if (DrawX == 10'd0) begin
                if (fill_done_q) begin
                    act_q       <= ~act_q;
                    fill_done_q <= 1'b0;
                end else if (y_win) begin
                    line_miss_q <= 1'b1;
                end
            end
            if (state_q == PD) begin
                lbuf[~act_q][9] <= ram_rdata;
                fill_done_q     <= 1'b1;
            end
        end
    end

    always_comb begin
        col = '0;
        for (int k = 1; k < 10; k++)
            if (DrawX >= 10'(120 + 40 * k)) col = 4'(k);
        in_win  = (DrawX >= 10'd120) && (DrawX <= 10'd519) && y_win;
        blockID = '0;
        if (Reset_n && in_win) blockID = lbuf[act_q][col];
    end

    assign line_miss = line_miss_q;

`ifdef SCHED_STATS_EN
    always_ff @(posedge Clk) begin
        if (!Reset_n)
            stall_cnt <= '0;
        else if (gm_req && !gm_gnt && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_tile_fetch_scheduler.sv
// Bench for tile_fetch_scheduler: level-RAM model plus scoreboard queue of expected addresses/data.
module tb_tile_fetch_scheduler;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [9:0] DrawX, DrawY;
    logic [9:0] scroll_col;
    logic [2:0] blockID;
    logic       gm_req, gm_we;
    logic [9:0] gm_addr;
    logic [2:0] gm_wdata;
    logic       gm_gnt, gm_rvalid;
    logic [2:0] gm_rdata;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [2:0] ram_wdata;
    logic [2:0] ram_rdata;
    logic       line_miss;
`ifdef SCHED_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    // Level map: untouched tiles read back address mod 8; written tiles remembered.
    bit       wr_flag [1024];
    bit [2:0] wmem    [1024];

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        ram_rdata <= wr_flag[ram_addr] ? wmem[ram_addr] : ram_addr[2:0];
        if (ram_we) begin
            wr_flag[ram_addr] <= 1'b1;
            wmem[ram_addr]    <= ram_wdata;
        end
    end

    tile_fetch_scheduler dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .scroll_col (scroll_col),
        .blockID    (blockID),
        .gm_req     (gm_req),
        .gm_we      (gm_we),
        .gm_addr    (gm_addr),
        .gm_wdata   (gm_wdata),
        .gm_gnt     (gm_gnt),
        .gm_rvalid  (gm_rvalid),
        .gm_rdata   (gm_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
`ifdef SCHED_STATS_EN
        .stall_cnt  (stall_cnt),
`endif
        .line_miss  (line_miss)
    );

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        int e;
        Reset_n = 1'b1;
        DrawY = 10'd99;
        DrawX = 10'd640;
        cyc();
        DrawX = 10'd641;
        cyc();
        cyc();
        Reset_n = 1'b0;
        gm_req  = 1'b1;
        gm_we   = 1'b0;
        gm_addr = 10'd5;
        DrawX   = 10'd200;
        DrawY   = 10'd100;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if (gm_gnt !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 10'd0) begin
                errors++;
                $display("FAIL reset_outputs gnt=%b we=%b addr=%0d want 0/0/0", gm_gnt, ram_we, ram_addr);
            end
            checks++;
            if (blockID !== 3'd0 || line_miss !== 1'b0) begin
                errors++;
                $display("FAIL reset_blockid blockID=%0d line_miss=%b want 0/0", blockID, line_miss);
            end
            cyc();
        end
        Reset_n = 1'b1;
        DrawX   = 10'd700;
        @(negedge Clk);
        checks++;
        if (gm_rvalid !== 1'b0 || gm_gnt !== 1'b1) begin
            errors++;
            $display("FAIL reset_release rvalid=%b gnt=%b want 0/1", gm_rvalid, gm_gnt);
        end
        exp_q.push_back(5);
        cyc();
        gm_req = 1'b0;
        @(negedge Clk);
        e = exp_q.pop_front();
        checks++;
        if (gm_rvalid !== 1'b1 || gm_rdata !== 3'(e)) begin
            errors++;
            $display("FAIL reset_read rvalid=%b rdata=%0d want 1/%0d", gm_rvalid, gm_rdata, e);
        end
        cyc();
        gm_req  = 1'b1;
        gm_addr = 10'd6;
        @(negedge Clk);
        checks++;
        if (gm_gnt !== 1'b1) begin
            errors++;
            $display("FAIL reset_gr_grant gnt=%b want 1", gm_gnt);
        end
        cyc();
        gm_req  = 1'b0;
        Reset_n = 1'b0;
        @(negedge Clk);
        checks++;
        if (gm_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_gr_drop rvalid=%b want 0", gm_rvalid);
        end
        cyc();
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (gm_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_gr_after rvalid=%b want 0", gm_rvalid);
        end
        cyc();
    endtask

    task automatic test_prefetch();
        int e;
        scroll_col = 10'd0;
        DrawY = 10'd39;
        DrawX = 10'd640;
        for (int i = 0; i < 10; i++) exp_q.push_back(i);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            e = exp_q.pop_front();
            checks++;
            if (ram_addr !== 10'(e) || ram_we !== 1'b0) begin
                errors++;
                $display("FAIL pf_addr[%0d] addr=%0d we=%b want %0d/0", i, ram_addr, ram_we, e);
            end
            cyc();
            DrawX = 10'(641 + i);
        end
        cyc();
        DrawY = 10'd40;
        DrawX = 10'd0;
        cyc();
        for (int k = 0; k < 10; k++) begin
            DrawX = 10'(120 + 40 * k);
            exp_q.push_back(k % 8);
            @(negedge Clk);
            e = exp_q.pop_front();
            checks++;
            if (blockID !== 3'(e)) begin
                errors++;
                $display("FAIL pf_blockid col%0d got=%0d want %0d", k, blockID, e);
            end
            cyc();
        end
        DrawX = 10'd519;
        @(negedge Clk);
        checks++;
        if (blockID !== 3'd1) begin
            errors++;
            $display("FAIL win_edge_519 got=%0d want 1", blockID);
        end
        cyc();
        DrawX = 10'd520;
        @(negedge Clk);
        checks++;
        if (blockID !== 3'd0) begin
            errors++;
            $display("FAIL win_edge_520 got=%0d want 0", blockID);
        end
        cyc();
    endtask

    task automatic test_game_read();
        int e;
        DrawX   = 10'd700;
        gm_req  = 1'b1;
        gm_we   = 1'b0;
        gm_addr = 10'd5;
        @(negedge Clk);
        checks++;
        if (gm_gnt !== 1'b1 || ram_addr !== 10'd5 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL gm_read_grant gnt=%b addr=%0d we=%b want 1/5/0", gm_gnt, ram_addr, ram_we);
        end
        exp_q.push_back(5);
        cyc();
        gm_req = 1'b0;
        @(negedge Clk);
        e = exp_q.pop_front();
        checks++;
        if (gm_rvalid !== 1'b1 || gm_rdata !== 3'(e)) begin
            errors++;
            $display("FAIL gm_read_data rvalid=%b rdata=%0d want 1/%0d", gm_rvalid, gm_rdata, e);
        end
        cyc();
        @(negedge Clk);
        checks++;
        if (gm_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL gm_rvalid_pulse rvalid=%b want 0", gm_rvalid);
        end
        cyc();
    endtask

    task automatic test_contention();
        int e, n;
        bit got;
        int stall0;
        n = 0;
        got = 1'b0;
        stall0 = 0;
        DrawY   = 10'd40;
        DrawX   = 10'd640;
        gm_req  = 1'b1;
        gm_we   = 1'b0;
        gm_addr = 10'd2;
        while (n < 30 && !got) begin
            @(negedge Clk);
`ifdef SCHED_STATS_EN
            if (n == 0) stall0 = int'(stall_cnt);
`endif
            if (gm_gnt) got = 1'b1;
            else begin
                cyc();
                n++;
                DrawX = 10'(640 + n);
            end
        end
        checks++;
        if (!got || n != 11) begin
            errors++;
            $display("FAIL contention_latency got=%0d cycles (granted=%0b) want 11", n, got);
        end
`ifdef SCHED_STATS_EN
        checks++;
        if (int'(stall_cnt) - stall0 != 11) begin
            errors++;
            $display("FAIL stall_cnt delta=%0d want 11", int'(stall_cnt) - stall0);
        end
`endif
        exp_q.push_back(2);
        cyc();
        gm_req = 1'b0;
        @(negedge Clk);
        e = exp_q.pop_front();
        checks++;
        if (gm_rvalid !== 1'b1 || gm_rdata !== 3'(e)) begin
            errors++;
            $display("FAIL contention_read rvalid=%b rdata=%0d want 1/%0d", gm_rvalid, gm_rdata, e);
        end
        cyc();
    endtask

    task automatic test_write_coherency();
        int e;
        DrawY = 10'd59;
        DrawX = 10'd0;
        cyc();
        DrawX = 10'd640;
        cyc();
        DrawX = 10'd700;
        repeat (11) cyc();
        DrawY = 10'd60;
        DrawX = 10'd0;
        cyc();
        DrawX = 10'd240;
        exp_q.push_back(3);
        @(negedge Clk);
        e = exp_q.pop_front();
        checks++;
        if (blockID !== 3'(e)) begin
            errors++;
            $display("FAIL wr_before got=%0d want %0d", blockID, e);
        end
        cyc();
        DrawX    = 10'd300;
        gm_req   = 1'b1;
        gm_we    = 1'b1;
        gm_addr  = 10'd3;
        gm_wdata = 3'b110;
        @(negedge Clk);
        checks++;
        if (gm_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'd3 || ram_wdata !== 3'b110) begin
            errors++;
            $display("FAIL wr_issue gnt=%b we=%b addr=%0d wdata=%0d want 1/1/3/6", gm_gnt, ram_we, ram_addr, ram_wdata);
        end
        cyc();
        gm_req = 1'b0;
        gm_we  = 1'b0;
        DrawX  = 10'd250;
        exp_q.push_back(3);
        @(negedge Clk);
        e = exp_q.pop_front();
        checks++;
        if (blockID !== 3'(e) || gm_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_same_line blockID=%0d rvalid=%b want %0d/0", blockID, gm_rvalid, e);
        end
        cyc();
        DrawX = 10'd640;
        cyc();
        DrawX = 10'd700;
        repeat (11) cyc();
        DrawY = 10'd61;
        DrawX = 10'd0;
        cyc();
        DrawX = 10'd240;
        exp_q.push_back(6);
        @(negedge Clk);
        e = exp_q.pop_front();
        checks++;
        if (blockID !== 3'(e) || line_miss !== 1'b0) begin
            errors++;
            $display("FAIL wr_next_line blockID=%0d line_miss=%b want %0d/0", blockID, line_miss, e);
        end
        cyc();
    endtask

    task automatic test_line_miss();
        int e;
        DrawY = 10'd62;
        DrawX = 10'd0;
        cyc();
        DrawX = 10'd240;
        exp_q.push_back(6);
        @(negedge Clk);
        e = exp_q.pop_front();
        checks++;
        if (line_miss !== 1'b1 || blockID !== 3'(e)) begin
            errors++;
            $display("FAIL line_miss flag=%b blockID=%0d want 1/%0d", line_miss, blockID, e);
        end
        cyc();
    endtask

    task automatic test_wrap();
        int e;
        DrawY      = 10'd62;
        DrawX      = 10'd640;
        scroll_col = 10'd1020;
        for (int i = 0; i < 10; i++) exp_q.push_back((1020 + i) % 1024);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            e = exp_q.pop_front();
            checks++;
            if (ram_addr !== 10'(e)) begin
                errors++;
                $display("FAIL wrap_addr[%0d] addr=%0d want %0d", i, ram_addr, e);
            end
            cyc();
            DrawX      = 10'(641 + i);
            scroll_col = 10'd0;
        end
        repeat (2) cyc();
    endtask

    task automatic test_row_advance();
        int e;
        Reset_n = 1'b0;
        cyc();
        Reset_n    = 1'b1;
        scroll_col = 10'd0;
        for (int y = 39; y <= 79; y++) begin
            DrawY = 10'(y);
            DrawX = 10'd0;
            cyc();
            DrawX = 10'd640;
            if (y >= 78)
                for (int i = 0; i < 10; i++) exp_q.push_back(((y + 1 - 40) / 40) * 64 + i);
            for (int i = 0; i < 10; i++) begin
                if (y >= 78) begin
                    @(negedge Clk);
                    e = exp_q.pop_front();
                    checks++;
                    if (ram_addr !== 10'(e)) begin
                        errors++;
                        $display("FAIL row_addr y=%0d c=%0d addr=%0d want %0d", y, i, ram_addr, e);
                    end
                end
                cyc();
                DrawX = 10'd700;
            end
            cyc();
        end
        DrawY = 10'd80;
        DrawX = 10'd0;
        cyc();
        DrawX = 10'd700;
        @(negedge Clk);
        checks++;
        if (line_miss !== 1'b0) begin
            errors++;
            $display("FAIL row_no_miss line_miss=%b want 0", line_miss);
        end
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        Reset_n    = 1'b0;
        DrawX      = 10'd700;
        DrawY      = 10'd0;
        scroll_col = 10'd0;
        gm_req     = 1'b0;
        gm_we      = 1'b0;
        gm_addr    = 10'd0;
        gm_wdata   = 3'd0;
        cyc();
        cyc();
        test_reset();
        test_prefetch();
        test_game_read();
        test_contention();
        test_write_coherency();
        test_line_miss();
        test_wrap();
        test_row_advance();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
